// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply/divide unit with valid/ready in and out
module muldiv_unit #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int              STEPS   = XLEN / BITS_PER_CYCLE;
   localparam int              CNT_W   = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  counter_q;
   logic [2:0]        op_q;
   // Multiply: hi_q/lo_q form the 2*XLEN accumulator, lo_q starts as the multiplier.
   // Divide:   hi_q is the partial remainder, lo_q shifts dividend out / quotient in.
   logic [XLEN-1:0]   hi_q, lo_q, mcand_q, result_q;
   logic              neg_res_q, neg_rem_q;
   logic              in_ready_q, out_valid_q, busy_q;

   logic              a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   special_res;

   logic [XLEN-1:0]   hi_d, lo_d;
   logic [XLEN:0]     rshift, diff, sum;

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, result_d;

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign busy      = busy_q;

   // Decode the incoming op: operand signedness, magnitudes and the special-case shortcuts.
   always_comb begin
      a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
      b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
      a_neg    = a_signed & in_a[XLEN-1];
      b_neg    = b_signed & in_b[XLEN-1];
      a_mag    = a_neg ? -in_a : in_a;
      b_mag    = b_neg ? -in_b : in_b;
      div_zero = op[2] && (in_b == '0);
      div_ovf  = ((op == 3'd4) || (op == 3'd6)) && (in_a == MIN_NEG) && (in_b == '1);
      if (div_zero) begin
         special_res = op[1] ? in_a : '1;
      end else begin
         special_res = op[1] ? '0 : MIN_NEG;
      end
   end

   // One CALC cycle: BITS_PER_CYCLE shift-add or restoring shift-subtract steps.
   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      rshift = '0;
      diff   = '0;
      sum    = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (op_q[2]) begin
            rshift = {hi_d, lo_d[XLEN-1]};
            diff   = rshift - {1'b0, mcand_q};
            if (!diff[XLEN]) begin
               hi_d = diff[XLEN-1:0];
               lo_d = {lo_d[XLEN-2:0], 1'b1};
            end else begin
               hi_d = rshift[XLEN-1:0];
               lo_d = {lo_d[XLEN-2:0], 1'b0};
            end
         end else begin
            sum          = {1'b0, hi_d} + (lo_d[0] ? {1'b0, mcand_q} : '0);
            {hi_d, lo_d} = {sum, lo_d[XLEN-1:1]};
         end
      end
   end

   // Sign correction of the magnitude result and selection of the requested half/part.
   always_comb begin
      prod = {hi_q, lo_q};
      if (neg_res_q) begin
         prod = -prod;
      end
      quo = neg_res_q ? -lo_q : lo_q;
      rem = neg_rem_q ? -hi_q : hi_q;
      case (op_q)
         3'd0:                result_d = prod[XLEN-1:0];
         3'd1, 3'd2, 3'd3:    result_d = prod[2*XLEN-1:XLEN];
         3'd4, 3'd5:          result_d = quo;
         default:             result_d = rem;
      endcase
   end

   // Control FSM and datapath registers; reset beats flush, flush beats accept and handshake.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         counter_q   <= '0;
         op_q        <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         mcand_q     <= '0;
         result_q    <= '0;
         neg_res_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else if (flush) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  op_q       <= op;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (div_zero || div_ovf) begin
                     result_q    <= special_res;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     counter_q <= CNT_W'(STEPS);
                     neg_res_q <= a_neg ^ b_neg;
                     neg_rem_q <= a_neg;
                     hi_q      <= '0;
                     lo_q      <= op[2] ? a_mag : b_mag;
                     mcand_q   <= op[2] ? b_mag : a_mag;
                     state_q   <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               hi_q      <= hi_d;
               lo_q      <= lo_d;
               counter_q <= counter_q - CNT_W'(1);
               if (counter_q == CNT_W'(1)) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               result_q    <= result_d;
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit at 1 and 4 bits per cycle
module tb_muldiv_unit;

   localparam logic [31:0] MINV = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [2:0]  op;
   logic [31:0] in_a, in_b;
   logic [1:0]  in_ready, out_valid, busy;
   logic [31:0] result [2];

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;
   int steps [2] = '{32, 8};

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
      .op(op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid[0]), .out_ready(out_ready),
      .result(result[0]), .busy(busy[0]));

   muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
      .op(op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid[1]), .out_ready(out_ready),
      .result(result[1]), .busy(busy[1]));

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s [bpc%0d] t=%0t: got %h expected %h", name, (k == 0) ? 1 : 4, $time, act, exp);
      end
   endtask

   // RV32M reference result computed with 64-bit arithmetic
   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ub, p;
      longint unsigned uu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      uu = {32'b0, a} * {32'b0, b};
      ref_op = '0;
      case (f)
         3'd0: begin p = sa * sb; ref_op = p[31:0]; end
         3'd1: begin p = sa * sb; ref_op = p[63:32]; end
         3'd2: begin p = sa * ub; ref_op = p[63:32]; end
         3'd3: ref_op = uu[63:32];
         3'd4: begin
            if (b == 0) ref_op = '1;
            else if (a == MINV && b == '1) ref_op = MINV;
            else begin p = sa / sb; ref_op = p[31:0]; end
         end
         3'd5: ref_op = (b == 0) ? '1 : a / b;
         3'd6: begin
            if (b == 0) ref_op = a;
            else if (a == MINV && b == '1) ref_op = '0;
            else begin p = sa % sb; ref_op = p[31:0]; end
         end
         default: ref_op = (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && ((b == 0) || (!f[0] && a == MINV && b == '1));
   endfunction

   // Transaction-level model: an accepted op becomes visible after a fixed latency and
   // stays until handshaken; reset and flush drop it.
   int          m_wait [2];
   bit          m_pend [2];
   bit          m_val  [2];
   logic [31:0] m_res  [2];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!reset) begin
            m_pend[k] <= 1'b0; m_val[k] <= 1'b0; m_res[k] <= '0;
         end else if (flush) begin
            m_pend[k] <= 1'b0; m_val[k] <= 1'b0;
         end else if (m_val[k]) begin
            if (out_ready) m_val[k] <= 1'b0;
         end else if (m_pend[k]) begin
            m_wait[k] <= m_wait[k] - 1;
            if (m_wait[k] == 1) begin
               m_pend[k] <= 1'b0; m_val[k] <= 1'b1;
            end
         end else if (in_valid) begin
            m_res[k] <= ref_op(op, in_a, in_b);
            if (is_special(op, in_a, in_b)) m_val[k] <= 1'b1;
            else begin
               m_pend[k] <= 1'b1; m_wait[k] <= steps[k] + 1;
            end
         end
      end
   end

   // Compare every cycle against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk("out_valid", k, out_valid[k], m_val[k]);
            chk("in_ready", k, in_ready[k], !(m_pend[k] || m_val[k]));
            chk("busy", k, busy[k], m_pend[k] || m_val[k]);
            if (m_val[k]) chk("result", k, result[k], m_res[k]);
         end
      end
   end

   task automatic wait_idle(input bit rnd);
      int c;
      c = 0;
      while (in_ready != 2'b11 && c < 300) begin
         if (rnd) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 199) == 0);
         end
         @(negedge clk);
         c++;
      end
      flush = 1'b0;
      if (c >= 300) chk("idle_timeout", 0, 32'd0, 32'd1);
   endtask

   // Directed op with out_ready high: literal result and accept-to-valid latency on both units
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input bit special);
      int          lat  [2];
      logic [31:0] got  [2];
      bit          seen [2];
      seen = '{0, 0}; lat = '{0, 0}; got = '{0, 0};
      out_ready = 1'b1;
      in_valid = 1'b1; op = f; in_a = a; in_b = b;
      @(negedge clk);
      in_valid = 1'b0; op = 3'($urandom); in_a = $urandom; in_b = $urandom;
      for (int c = 1; c <= 200 && !(seen[0] && seen[1]); c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!seen[k] && out_valid[k]) begin
               seen[k] = 1'b1; lat[k] = c; got[k] = result[k];
            end
         end
         if (!(seen[0] && seen[1])) @(negedge clk);
      end
      for (int k = 0; k < 2; k++) begin
         chk("latency", k, 32'(lat[k]), special ? 32'd1 : 32'(steps[k] + 2));
         chk("result_lit", k, got[k], exp_res);
      end
      wait_idle(1'b0);
   endtask

   task automatic pick(output logic [31:0] v);
      case ($urandom_range(0, 5))
         0: v = $urandom;
         1: v = '0;
         2: v = MINV;
         3: v = '1;
         4: v = 32'($urandom_range(0, 15));
         default: v = 32'd0 - 32'($urandom_range(1, 15));
      endcase
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, b;
      int c;
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; in_a = '0; in_b = '0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_in_ready", k, in_ready[k], 1);
         chk("rst_out_valid", k, out_valid[k], 0);
         chk("rst_busy", k, busy[k], 0);
         chk("rst_result", k, result[k], 0);
      end
      reset = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
      run_op(3'd1, MINV, MINV, 32'h4000_0000, 1'b0);
      run_op(3'd2, MINV, MINV, 32'hC000_0000, 1'b0);
      run_op(3'd3, MINV, MINV, 32'h4000_0000, 1'b0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
      run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
      run_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
      run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
      run_op(3'd7, 32'd5, 32'd0, 32'd5, 1'b1);
      run_op(3'd4, MINV, 32'hFFFF_FFFF, MINV, 1'b1);
      run_op(3'd6, MINV, 32'hFFFF_FFFF, 32'd0, 1'b1);

      // Back-pressure: result held, in_ready low until one cycle after the handshake
      out_ready = 1'b0;
      in_valid = 1'b1; op = 3'd5; in_a = 32'd100; in_b = 32'd7;
      @(negedge clk);
      in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
      c = 0;
      while (!out_valid[0] && c < 100) begin @(negedge clk); c++; end
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", 0, out_valid[0], 1);
         chk("bp_result", 0, result[0], 32'd14);
         chk("bp_in_ready", 0, in_ready[0], 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      chk("bp_hs_in_ready", 0, in_ready[0], 0);
      @(negedge clk);
      chk("bp_after_in_ready", 0, in_ready[0], 1);
      chk("bp_after_out_valid", 0, out_valid[0], 0);
      wait_idle(1'b0);

      // Flush on the 10th edge after accept, with a new op offered in the same cycle
      in_valid = 1'b1; op = 3'd4; in_a = 32'hFFFF_FFF9; in_b = 32'd2;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; op = 3'd0; in_a = 32'd3; in_b = 32'd5;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_in_ready", 0, in_ready[0], 1);
      chk("flush_out_valid", 0, out_valid[0], 0);
      chk("flush_busy", 0, busy[0], 0);
      c = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid[0]) c++;
         @(negedge clk);
      end
      chk("flush_no_result", 0, 32'(c), 32'd0);

      // Reset in the middle of an op
      in_valid = 1'b1; op = 3'd0; in_a = 32'd1234; in_b = 32'd77;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("midrst_in_ready", k, in_ready[k], 1);
         chk("midrst_out_valid", k, out_valid[k], 0);
         chk("midrst_busy", k, busy[k], 0);
         chk("midrst_result", k, result[k], 0);
      end
      reset = 1'b1;
      @(negedge clk);

      // Randomized ops with random back-pressure and occasional flush
      for (int n = 0; n < 400; n++) begin
         wait_idle(1'b1);
         pick(a); pick(b);
         in_valid = 1'b1; op = 3'($urandom); in_a = a; in_b = b;
         flush = ($urandom_range(0, 29) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         in_valid = 1'b0; flush = 1'b0; in_a = $urandom; in_b = $urandom; op = 3'($urandom);
      end
      out_ready = 1'b1;
      wait_idle(1'b0);
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
